host_mem_arbiter: RTL and testbench
===================================

HOST_MEM_ARBITER -- requirements
Module: host_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: max cycles a transaction waits for host ready before abort.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 host_init  input  1  host link up; leaves STARTUP.
REQ-005 i_rd_req, i_miss_addr  input  1, 32  instruction-cache fill request and word address.
REQ-006 d_rd_req, d_miss_addr  input  1, 32  data-cache fill request and word address.
REQ-007 wb_req, wb_addr, wb_data  input  1, 32, 512  write-back request, word address, line data.
REQ-008 host_rd_ready, host_wr_ready  input  1 each  host read data valid / host accepts write.
REQ-009 cpu_addr  output  64  host byte address, {46'b0, addr[15:0], 2'b00} of the granted request; 0 otherwise.
REQ-010 host_rgo, host_re, host_wgo, host_we  output  1 each  host read/write go and enable strobes.
REQ-011 host_data_bus_write_out  output  512  latched write-back line.
REQ-012 host_rd_addr  output  32  latched fill address, broadcast to caches during RD; 0 otherwise.
REQ-013 i_fill_done, d_fill_done, wb_done  output  1 each  one-cycle completion pulses.
REQ-014 timeout_err  output  1  sticky abort flag.
REQ-015 busy  output  1  high in RD or WR.

Function
REQ-016 FSM states: STARTUP, IDLE, RD, WR; STARTUP -> IDLE on host_init high; host_init ignored afterwards.
REQ-017 In IDLE, requests arbitrate round-robin in order i, d, wb, starting after the last granted requester; after reset, i has priority.
REQ-018 On grant in IDLE, address (and wb_data for wb) latched in the same edge; next state RD for i/d, WR for wb.
REQ-019 Request inputs are sampled only in IDLE; changes during RD/WR have no effect.
REQ-020 RD: host_rgo=1, cpu_addr and host_rd_addr from latched address; host_re=1 combinationally in the cycle host_rd_ready=1; that cycle pulses the granted fill_done; next state IDLE.
REQ-021 WR: host_wgo=1, host_data_bus_write_out = latched line; host_we=1 combinationally in the cycle host_wr_ready=1; that cycle pulses wb_done; next state IDLE.
REQ-022 host_rd_ready in IDLE/WR/STARTUP and host_wr_ready in IDLE/RD/STARTUP are ignored.
REQ-023 Minimum one IDLE cycle between transactions; requester drops its req in the cycle after its done pulse and therefore is not re-granted.
REQ-024 Wait counter (log2(TIMEOUT) + 1 bits) clears on entering RD/WR, increments every RD/WR cycle without ready.
REQ-025 Counter reaching TIMEOUT-1 without ready: timeout_err set, no done pulse, no re/we, state -> IDLE, round-robin pointer advances past the aborted requester.
REQ-026 Ready arriving in the same cycle as counter=TIMEOUT-1: completes normally, no timeout.
REQ-027 timeout_err clears only on reset.
REQ-028 Grant-to-go latency: req high at edge k in IDLE -> host_rgo/host_wgo high from cycle after edge k.

Reset
REQ-029 rst_n low asynchronously forces STARTUP, pointer to i, counter 0, latched address/data 0, timeout_err 0.
REQ-030 During reset all outputs are 0; reset mid-transaction drops it with no done pulse.

Verification
REQ-031 host_init=1, then i_rd_req=1, i_miss_addr=0x0000_1234, host_rd_ready 3 cycles later -> cpu_addr=0x48D0, host_re and i_fill_done one-cycle pulses, return to IDLE.
REQ-032 i_rd_req, d_rd_req, wb_req all high continuously -> grant order i, d, wb, i, each separated by one IDLE cycle.
REQ-033 wb_req, wb_addr=0x10, wb_data=512'hA5..A5, host_wr_ready after 2 cycles -> cpu_addr=0x40, write_out=A5..A5, host_we and wb_done pulse.
REQ-034 TIMEOUT=8, d_rd_req, no ready -> after 8 RD cycles timeout_err=1, no d_fill_done, next grant goes to wb/i.
REQ-035 rst_n low during RD -> outputs 0 immediately, STARTUP; requests ignored until host_init.

Source files
------------

// File: rtl/host_mem_arbiter_if.sv
// Host memory arbiter bus bundle.
// Carries the cache fill / write-back requests in and the host strobes,
// address, data and status flags out.
//   master : the arbiter (drives host strobes, completions, status)
//   slave  : requesters + host model (drive requests, host ready)
interface host_mem_arbiter_if;
  logic         host_init;
  logic         i_rd_req;
  logic [31:0]  i_miss_addr;
  logic         d_rd_req;
  logic [31:0]  d_miss_addr;
  logic         wb_req;
  logic [31:0]  wb_addr;
  logic [511:0] wb_data;
  logic         host_rd_ready;
  logic         host_wr_ready;

  logic [63:0]  cpu_addr;
  logic         host_rgo;
  logic         host_re;
  logic         host_wgo;
  logic         host_we;
  logic [511:0] host_data_bus_write_out;
  logic [31:0]  host_rd_addr;
  logic         i_fill_done;
  logic         d_fill_done;
  logic         wb_done;
  logic         timeout_err;
  logic         busy;

  modport master (
    input  host_init, i_rd_req, i_miss_addr, d_rd_req, d_miss_addr,
           wb_req, wb_addr, wb_data, host_rd_ready, host_wr_ready,
    output cpu_addr, host_rgo, host_re, host_wgo, host_we,
           host_data_bus_write_out, host_rd_addr, i_fill_done,
           d_fill_done, wb_done, timeout_err, busy
  );

  modport slave (
    output host_init, i_rd_req, i_miss_addr, d_rd_req, d_miss_addr,
           wb_req, wb_addr, wb_data, host_rd_ready, host_wr_ready,
    input  cpu_addr, host_rgo, host_re, host_wgo, host_we,
           host_data_bus_write_out, host_rd_addr, i_fill_done,
           d_fill_done, wb_done, timeout_err, busy
  );
endinterface

// File: rtl/host_mem_arbiter.sv
// Host memory arbiter: serialises I-cache fills, D-cache fills and
// write-backs onto a single host link, one transaction at a time.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : host_mem_arbiter_if.master (requests in; host strobes,
//                address/data, completion pulses, timeout_err, busy out)
// Parameter TIMEOUT: cycles a transaction may wait for host ready.
module host_mem_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst_n,
  host_mem_arbiter_if.master bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // requester ids
  localparam logic [1:0] ID_I  = 2'd0;
  localparam logic [1:0] ID_D  = 2'd1;
  localparam logic [1:0] ID_WB = 2'd2;

  typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_RD, ST_WR} state_t;

  state_t         state_q, state_d;
  logic [1:0]     last_q, last_d;   // last granted (also owner of current xfer)
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [511:0]   line_q, line_d;
  logic           err_q, err_d;

  // round-robin pick; bit 3 is a never-set pad so the index stays in range
  logic [3:0]     req_v;
  logic [1:0]     first, second, third, gnt_id;
  logic           gnt_vld;

  assign req_v = {1'b0, bus.wb_req, bus.d_rd_req, bus.i_rd_req};

  always_comb begin
    first  = ID_I;
    second = ID_D;
    third  = ID_WB;
    case (last_q)
      ID_I:    begin first = ID_D;  second = ID_WB; third = ID_I; end
      ID_D:    begin first = ID_WB; second = ID_I;  third = ID_D; end
      default: ;
    endcase
    gnt_vld = |req_v[2:0];
    if (req_v[first])       gnt_id = first;
    else if (req_v[second]) gnt_id = second;
    else                    gnt_id = third;
  end

  logic        rgo, re, wgo, we, i_done, d_done, w_done;
  logic [63:0] cpu_addr_c;
  logic [31:0] rd_addr_c;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    line_d     = line_q;
    err_d      = err_q;
    rgo        = 1'b0;
    re         = 1'b0;
    wgo        = 1'b0;
    we         = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    w_done     = 1'b0;
    cpu_addr_c = '0;
    rd_addr_c  = '0;
    case (state_q)
      ST_STARTUP: if (bus.host_init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (gnt_vld) begin
          last_d = gnt_id;
          cnt_d  = '0;
          case (gnt_id)
            ID_I:    begin addr_d = bus.i_miss_addr; state_d = ST_RD; end
            ID_D:    begin addr_d = bus.d_miss_addr; state_d = ST_RD; end
            default: begin
              addr_d  = bus.wb_addr;
              line_d  = bus.wb_data;
              state_d = ST_WR;
            end
          endcase
        end
      end
      ST_RD: begin
        rgo        = 1'b1;
        cpu_addr_c = {46'b0, addr_q[15:0], 2'b00};
        rd_addr_c  = addr_q;
        // ready on the last allowed cycle still wins over the abort
        if (bus.host_rd_ready) begin
          re      = 1'b1;
          i_done  = (last_q == ID_I);
          d_done  = (last_q == ID_D);
          state_d = ST_IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WR: begin
        wgo        = 1'b1;
        cpu_addr_c = {46'b0, addr_q[15:0], 2'b00};
        if (bus.host_wr_ready) begin
          we      = 1'b1;
          w_done  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // last_q resets to wb so that i holds top priority after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STARTUP;
      last_q  <= ID_WB;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  assign bus.cpu_addr                = cpu_addr_c;
  assign bus.host_rgo                = rgo;
  assign bus.host_re                 = re;
  assign bus.host_wgo                = wgo;
  assign bus.host_we                 = we;
  assign bus.host_data_bus_write_out = line_q;
  assign bus.host_rd_addr            = rd_addr_c;
  assign bus.i_fill_done             = i_done;
  assign bus.d_fill_done             = d_done;
  assign bus.wb_done                 = w_done;
  assign bus.timeout_err             = err_q;
  assign bus.busy                    = (state_q == ST_RD) || (state_q == ST_WR);

endmodule

// File: tb/tb_host_mem_arbiter.sv
module tb_host_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  host_mem_arbiter_if bus();
  host_mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for link, 1 = free, 2 = transfer in flight
  int           m_phase, m_owner, m_last, m_spent;
  logic [31:0]  m_addr;
  logic [511:0] m_line;
  logic         m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_owner <= 0; m_last <= 2; m_spent <= 0;
      m_addr <= '0; m_line <= '0; m_err <= 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.host_init) m_phase <= 1;
        1: begin
          int  pick;
          bit  found;
          bit  reqs [3];
          reqs[0] = bus.i_rd_req; reqs[1] = bus.d_rd_req; reqs[2] = bus.wb_req;
          found = 0; pick = 0;
          for (int k = 1; k <= 3; k++)
            if (!found && reqs[(m_last + k) % 3]) begin
              found = 1; pick = (m_last + k) % 3;
            end
          if (found) begin
            m_phase <= 2; m_owner <= pick; m_last <= pick; m_spent <= 0;
            m_addr <= (pick == 0) ? bus.i_miss_addr :
                      (pick == 1) ? bus.d_miss_addr : bus.wb_addr;
            if (pick == 2) m_line <= bus.wb_data;
          end
        end
        default: begin
          bit rdy;
          rdy = (m_owner == 2) ? bus.host_wr_ready : bus.host_rd_ready;
          if (rdy) m_phase <= 1;
          else if (m_spent + 1 == TO) begin m_phase <= 1; m_err <= 1'b1; end
          else m_spent <= m_spent + 1;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_log[$];

  always @(negedge clk) begin
    bit xfer, rd, wr;
    logic [63:0] e_cpu;
    xfer  = (m_phase == 2);
    rd    = xfer && (m_owner != 2);
    wr    = xfer && (m_owner == 2);
    e_cpu = xfer ? 64'(m_addr % 32'h10000) * 64'd4 : 64'd0;
    chk("busy", bus.busy, xfer);
    chk("rgo", bus.host_rgo, rd);
    chk("wgo", bus.host_wgo, wr);
    chk("re", bus.host_re, rd && bus.host_rd_ready);
    chk("we", bus.host_we, wr && bus.host_wr_ready);
    chk("i_done", bus.i_fill_done, rd && m_owner == 0 && bus.host_rd_ready);
    chk("d_done", bus.d_fill_done, rd && m_owner == 1 && bus.host_rd_ready);
    chk("wb_done", bus.wb_done, wr && bus.host_wr_ready);
    chk("cpu_addr", bus.cpu_addr, e_cpu);
    chk("rd_addr", bus.host_rd_addr, rd ? m_addr : 32'd0);
    chk("wr_line", bus.host_data_bus_write_out, m_line);
    chk("tmo_err", bus.timeout_err, m_err);
    if (bus.i_fill_done) done_log.push_back(0);
    if (bus.d_fill_done) done_log.push_back(1);
    if (bus.wb_done)     done_log.push_back(2);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  logic [511:0] a5;

  initial begin
    a5 = {16{32'hA5A5_A5A5}};
    bus.host_init = 0; bus.i_rd_req = 0; bus.i_miss_addr = 0;
    bus.d_rd_req = 0; bus.d_miss_addr = 0; bus.wb_req = 0; bus.wb_addr = 0;
    bus.wb_data = '0; bus.host_rd_ready = 0; bus.host_wr_ready = 0;
    cyc(3);
    rst_n = 1;
    @(negedge clk);
    chk("rst_cpu_addr", bus.cpu_addr, 64'd0);
    chk("rst_busy", bus.busy, 1'b0);

    // single I-fill, ready on third RD cycle
    bus.host_init = 1; cyc(1); bus.host_init = 0;
    bus.i_rd_req = 1; bus.i_miss_addr = 32'h0000_1234; cyc(1);
    bus.i_rd_req = 0; bus.i_miss_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("ifill_cpu_addr", bus.cpu_addr, 64'h48D0);
    chk("ifill_rd_addr", bus.host_rd_addr, 32'h1234);
    cyc(2); bus.host_rd_ready = 1;
    @(negedge clk);
    chk("ifill_re", bus.host_re, 1'b1);
    chk("ifill_done", bus.i_fill_done, 1'b1);
    cyc(1); bus.host_rd_ready = 0;
    @(negedge clk);
    chk("ifill_idle", bus.busy, 1'b0);

    // write-back, ready on second WR cycle
    bus.wb_req = 1; bus.wb_addr = 32'h10; bus.wb_data = a5; cyc(1);
    bus.wb_req = 0; bus.wb_data = '0;
    @(negedge clk);
    chk("wb_cpu_addr", bus.cpu_addr, 64'h40);
    chk("wb_line", bus.host_data_bus_write_out, a5);
    cyc(1); bus.host_wr_ready = 1;
    @(negedge clk);
    chk("wb_we", bus.host_we, 1'b1);
    chk("wb_done_lit", bus.wb_done, 1'b1);
    cyc(1); bus.host_wr_ready = 0;

    // all three requesting continuously, host always ready
    done_log.delete();
    bus.i_miss_addr = 32'h100; bus.d_miss_addr = 32'h200; bus.wb_addr = 32'h300;
    bus.i_rd_req = 1; bus.d_rd_req = 1; bus.wb_req = 1;
    bus.host_rd_ready = 1; bus.host_wr_ready = 1;
    cyc(8);
    bus.i_rd_req = 0; bus.d_rd_req = 0; bus.wb_req = 0;
    cyc(3);
    bus.host_rd_ready = 0; bus.host_wr_ready = 0;
    chk("rr_count", done_log.size(), 4);
    if (done_log.size() >= 4) begin
      chk("rr_0", done_log[0], 0);
      chk("rr_1", done_log[1], 1);
      chk("rr_2", done_log[2], 2);
      chk("rr_3", done_log[3], 0);
    end

    // D-fill that never gets ready; i and wb pending behind it
    bus.d_rd_req = 1; bus.d_miss_addr = 32'h55; cyc(1);
    bus.d_rd_req = 0; bus.i_rd_req = 1; bus.wb_req = 1;
    cyc(7);
    @(negedge clk);
    chk("tmo_before", bus.timeout_err, 1'b0);
    chk("tmo_still_busy", bus.busy, 1'b1);
    cyc(1);
    @(negedge clk);
    chk("tmo_set", bus.timeout_err, 1'b1);
    chk("tmo_idle", bus.busy, 1'b0);
    cyc(1);
    @(negedge clk);
    chk("tmo_next_wb", bus.host_wgo, 1'b1);
    bus.i_rd_req = 0; bus.wb_req = 0; bus.host_wr_ready = 1;
    @(negedge clk);
    cyc(1); bus.host_wr_ready = 0;

    // ready exactly on the last allowed cycle
    bus.i_rd_req = 1; bus.i_miss_addr = 32'h77; cyc(1);
    bus.i_rd_req = 0;
    cyc(7); bus.host_rd_ready = 1;
    @(negedge clk);
    chk("edge_done", bus.i_fill_done, 1'b1);
    cyc(1); bus.host_rd_ready = 0;
    @(negedge clk);
    chk("edge_idle", bus.busy, 1'b0);

    // reset in the middle of a read
    bus.i_rd_req = 1; cyc(1); bus.i_rd_req = 0; cyc(1);
    rst_n = 0; #1;
    chk("mid_rst_rgo", bus.host_rgo, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_cpu", bus.cpu_addr, 64'd0);
    chk("mid_rst_err", bus.timeout_err, 1'b0);
    cyc(2);
    rst_n = 1;
    bus.i_rd_req = 1; bus.d_rd_req = 1; bus.wb_req = 1; bus.i_miss_addr = 32'hABC;
    cyc(3);
    @(negedge clk);
    chk("startup_ignore", bus.busy, 1'b0);
    bus.host_init = 1; cyc(1); bus.host_init = 0; cyc(1);
    @(negedge clk);
    chk("post_rst_i_first", bus.host_rd_addr, 32'hABC);
    bus.i_rd_req = 0; bus.d_rd_req = 0; bus.wb_req = 0; bus.host_rd_ready = 1;
    cyc(1); bus.host_rd_ready = 0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
